// File: rtl/pe_tile_scheduler.sv
// Tile-level sequencer for PE_Controller: one weight load, then I_BlockCount rounds of
// input load / accumulate / back-pressured drain, finishing with a one-cycle done pulse.
module pe_tile_scheduler #(
  parameter int W_PEGroupSize     = 4,
  parameter int O_PEGroupSize     = 4,
  parameter int I_PEGroupSize     = W_PEGroupSize + O_PEGroupSize - 1,
  parameter int I_BlockCount      = 4,
  parameter int I_BlockCountWidth = 2,
  parameter int CntWidth          = 3
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         sclr,
  input  logic                         start,
  input  logic                         out_ready,
  output logic                         EN_W,
  output logic                         EN_I,
  output logic                         EN_O_In,
  output logic                         EN_O_Out,
  output logic                         busy,
  output logic                         done,
  output logic [I_BlockCountWidth-1:0] block_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_I = 3'd2,
    S_ACCUM  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [CntWidth-1:0]          CNT_ZERO = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0]          CNT_ONE  = CntWidth'(1);
  localparam logic [CntWidth-1:0]          W_LAST   = CntWidth'(W_PEGroupSize - 1);
  localparam logic [CntWidth-1:0]          I_LAST   = CntWidth'(I_PEGroupSize - 1);
  localparam logic [CntWidth-1:0]          O_LAST   = CntWidth'(O_PEGroupSize - 1);
  localparam logic [I_BlockCountWidth-1:0] BLK_ZERO = {I_BlockCountWidth{1'b0}};
  localparam logic [I_BlockCountWidth-1:0] BLK_ONE  = I_BlockCountWidth'(1);
  localparam logic [I_BlockCountWidth-1:0] BLK_LAST = I_BlockCountWidth'(I_BlockCount - 1);

  state_t                         state_q, state_d;
  logic [CntWidth-1:0]            cnt_q, cnt_d;
  logic [I_BlockCountWidth-1:0]   blk_q, blk_d;
  logic                           en_w_q, en_w_d;
  logic                           en_i_q, en_i_d;
  logic                           en_oin_q, en_oin_d;
  logic                           drain_q, drain_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  // Next-state, beat counter and block index; sclr overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    if (sclr) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      blk_d   = BLK_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_W;
            cnt_d   = CNT_ZERO;
            blk_d   = BLK_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD_W: begin
          if (cnt_q == W_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_LOAD_I;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_LOAD_I: begin
          if (cnt_q == I_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_ACCUM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_ACCUM: begin
          if (cnt_q == O_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DRAIN: begin
          // Only accepted beats count, so a stalled drain simply holds here.
          if (out_ready) begin
            if (cnt_q == O_LAST) begin
              cnt_d = CNT_ZERO;
              if (blk_q == BLK_LAST) begin
                state_d = S_DONE;
              end else begin
                blk_d   = blk_q + BLK_ONE;
                state_d = S_LOAD_I;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          blk_d   = BLK_ZERO;
        end
      endcase
    end
  end

  // Output flags decoded from the next state so they line up with the state register.
  always_comb begin
    en_w_d   = (state_d == S_LOAD_W);
    en_i_d   = (state_d == S_LOAD_I);
    en_oin_d = (state_d == S_ACCUM);
    drain_d  = (state_d == S_DRAIN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State, counter, block index and output flags.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      blk_q    <= BLK_ZERO;
      en_w_q   <= 1'b0;
      en_i_q   <= 1'b0;
      en_oin_q <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      en_w_q   <= en_w_d;
      en_i_q   <= en_i_d;
      en_oin_q <= en_oin_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The drain enable follows out_ready within the cycle, gated by the registered DRAIN flag.
  assign EN_W      = en_w_q;
  assign EN_I      = en_i_q;
  assign EN_O_In   = en_oin_q;
  assign EN_O_Out  = drain_q & out_ready;
  assign busy      = busy_q;
  assign done      = done_q;
  assign block_idx = blk_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Bench for pe_tile_scheduler: directed scenarios plus random start/out_ready/sclr traffic,
// checked cycle by cycle against a beat-schedule reference model.
module tb_pe_tile_scheduler;

  localparam int W  = 4;
  localparam int O  = 4;
  localparam int IG = W + O - 1;
  localparam int NB = 4;

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_W    = 3'd1;
  localparam logic [2:0] K_I    = 3'd2;
  localparam logic [2:0] K_A    = 3'd3;
  localparam logic [2:0] K_D    = 3'd4;
  localparam logic [2:0] K_X    = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] blk;
  } beat_t;

  logic       clk, aclr_n, sclr, start, out_ready, start1;
  logic       EN_W, EN_I, EN_O_In, EN_O_Out, busy, done;
  logic [1:0] block_idx;
  logic       EN_W1, EN_I1, EN_O_In1, EN_O_Out1, busy1, done1;
  logic [0:0] block_idx1;

  pe_tile_scheduler dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start), .out_ready(out_ready),
    .EN_W(EN_W), .EN_I(EN_I), .EN_O_In(EN_O_In), .EN_O_Out(EN_O_Out),
    .busy(busy), .done(done), .block_idx(block_idx)
  );

  pe_tile_scheduler #(.I_BlockCount(1), .I_BlockCountWidth(1)) dut1 (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start1), .out_ready(1'b1),
    .EN_W(EN_W1), .EN_I(EN_I1), .EN_O_In(EN_O_In1), .EN_O_Out(EN_O_Out1),
    .busy(busy1), .done(done1), .block_idx(block_idx1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    checks = 0;
  int    errors = 0;
  int    edge_n = 0;
  int    start_edge = 0;
  int    start1_edge = 0;
  int    done_cyc = -1;
  int    n_done = 0;
  int    n_w = 0, n_i = 0, n_a = 0, n_d = 0, n_acc_b1 = 0;
  int    dq1[$];
  beat_t q[$];
  logic [1:0] last_blk = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input logic [2:0] kind, input int blk, input int n);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.kind = kind;
      bt.blk  = 2'(blk);
      q.push_back(bt);
    end
  endtask

  // A tile is a fixed list of beats; drain beats are consumed only when accepted.
  task automatic model_fill();
    q.delete();
    push_beats(K_W, 0, W);
    for (int b = 0; b < NB; b++) begin
      push_beats(K_I, b, IG);
      push_beats(K_A, b, O);
      push_beats(K_D, b, O);
    end
    push_beats(K_X, NB - 1, 1);
  endtask

  task automatic model_edge();
    if (sclr) begin
      q.delete();
      last_blk = 2'd0;
    end else if (q.size() == 0) begin
      if (start) begin
        model_fill();
        start_edge = edge_n;
      end
    end else if (!(q[0].kind == K_D && !out_ready)) begin
      q.delete(0);
    end
    if (q.size() != 0) last_blk = q[0].blk;
  endtask

  task automatic check_outputs();
    logic [2:0] kind;
    kind = (q.size() != 0) ? q[0].kind : K_NONE;
    chk("en_w", EN_W, kind == K_W);
    chk("en_i", EN_I, kind == K_I);
    chk("en_o_in", EN_O_In, kind == K_A);
    chk("en_o_out", EN_O_Out, (kind == K_D) && out_ready);
    chk("busy", busy, q.size() != 0);
    chk("done", done, kind == K_X);
    chk("block_idx", block_idx, last_blk);
    chk("one_hot", $countones({EN_W, EN_I, EN_O_In, EN_O_Out}) <= 1, 1'b1);
    if (EN_W) n_w++;
    if (EN_I) n_i++;
    if (EN_O_In) n_a++;
    if (EN_O_Out) n_d++;
    if (EN_O_Out && last_blk == 2'd1) n_acc_b1++;
    if (done) begin
      n_done++;
      done_cyc = edge_n - start_edge + 1;
    end
    if (done1) dq1.push_back(edge_n - start1_edge + 1);
  endtask

  // One clock: inputs set by the caller hold for this cycle, checked mid-cycle, sampled at the edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    edge_n++;
    model_edge();
    if (start1) start1_edge = edge_n;
    #1;
  endtask

  task automatic clear_tallies();
    n_w = 0; n_i = 0; n_a = 0; n_d = 0; n_acc_b1 = 0; n_done = 0; done_cyc = -1;
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int cyc;
  int cyc1;
  bit second_sent;

  initial begin
    aclr_n = 1'b1; sclr = 1'b0; start = 1'b0; out_ready = 1'b1; start1 = 1'b0;
    #1 aclr_n = 1'b0;
    #2;
    chk("rst_en_w", EN_W, 1'b0);
    chk("rst_en_i", EN_I, 1'b0);
    chk("rst_en_o_in", EN_O_In, 1'b0);
    chk("rst_en_o_out", EN_O_Out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_block_idx", block_idx, 2'd0);
    @(posedge clk);
    #1 aclr_n = 1'b1;
    step();

    // Full tile with no back-pressure.
    clear_tallies();
    launch();
    repeat (70) step();
    chk("t1_done_cycle", done_cyc, 65);
    chk("t1_done_count", n_done, 1);
    chk("t1_en_w_beats", n_w, W);
    chk("t1_en_i_beats", n_i, NB * IG);
    chk("t1_en_o_in_beats", n_a, NB * O);
    chk("t1_en_o_out_beats", n_d, NB * O);

    // Three stalled cycles in the block-1 drain.
    clear_tallies();
    launch();
    for (int c = 0; c < 75; c++) begin
      cyc = edge_n - start_edge + 1;
      out_ready = !(cyc >= 32 && cyc <= 34);
      step();
    end
    out_ready = 1'b1;
    chk("bp_done_cycle", done_cyc, 68);
    chk("bp_block1_beats", n_acc_b1, O);

    // Starts during LOAD_I and during DONE are ignored.
    clear_tallies();
    launch();
    for (int c = 0; c < 75; c++) begin
      cyc = edge_n - start_edge + 1;
      start = (cyc == 6 || cyc == 65);
      step();
    end
    start = 1'b0;
    chk("ign_done_count", n_done, 1);
    chk("ign_done_cycle", done_cyc, 65);
    chk("ign_idle_after", busy, 1'b0);

    // Synchronous clear in block-2 ACCUM, then a fresh tile.
    clear_tallies();
    launch();
    for (int c = 0; c < 60; c++) begin
      cyc = edge_n - start_edge + 1;
      if (cyc == 44) begin
        chk("sclr_busy", busy, 1'b0);
        chk("sclr_en_o_in", EN_O_In, 1'b0);
        chk("sclr_block_idx", block_idx, 2'd0);
      end
      sclr = (cyc == 43);
      step();
    end
    sclr = 1'b0;
    chk("sclr_no_done", n_done, 0);
    clear_tallies();
    launch();
    repeat (70) step();
    chk("sclr_retile_done_cycle", done_cyc, 65);

    // Asynchronous reset between edges.
    launch();
    repeat (20) step();
    chk("pre_aclr_en_i", EN_I, 1'b1);
    #2 aclr_n = 1'b0;
    #1;
    chk("aclr_en_i", EN_I, 1'b0);
    chk("aclr_busy", busy, 1'b0);
    chk("aclr_block_idx", block_idx, 2'd0);
    chk("aclr_en_w", EN_W, 1'b0);
    q.delete();
    last_blk = 2'd0;
    aclr_n = 1'b1;
    repeat (3) step();

    // Single-block instance, back-to-back tiles.
    dq1.delete();
    second_sent = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cyc1 = edge_n - start1_edge + 1;
      if (cyc1 == 21 && !second_sent) begin
        chk("sb_busy_after_done", busy1, 1'b0);
        start1 = 1'b1;
        second_sent = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      step();
    end
    start1 = 1'b0;
    chk("sb_done_count", dq1.size(), 2);
    if (dq1.size() == 2) begin
      chk("sb_first_done_cycle", dq1[0], 20);
      chk("sb_second_done_cycle", dq1[1], 20);
    end

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sclr      = ($urandom_range(0, 63) == 0);
      step();
    end
    start = 1'b0; sclr = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
